mem_map_io: RTL

- Parametrised successor of the CPU memory system: unified word-addressed map holding RAM, tilemap, framebuffer and a memory-mapped I/O page.
- Serves the fetch port (combinational read), the data port (registered read) and one write port.
- The I/O page carries a keyboard scancode FIFO with status/overflow, and a free-running 32-bit cycle timer with a coherent snapshot.
- Sits between the CPU core, the PS/2 decoder (which supplies kbd_valid/kbd_code) and the video engine.

---
 rtl/mem_map_io.sv | 194 +++++++++++++++++++
 1 files changed

// File: rtl/mem_map_io.sv
// mem_map_io: unified word-addressed memory map (RAM, tilemap, framebuffer,
// I/O page). Fetch port reads combinationally, data port reads with one cycle
// of latency, and one write port. The I/O page exposes a keyboard scancode
// FIFO and a free-running 32-bit timer with a coherent high-half snapshot.
module mem_map_io #(
  parameter int             AW                = 16,
  parameter int             DW                = 16,
  parameter logic [AW-1:0]  TILEMAP_START     = 16'hC000,
  parameter logic [AW-1:0]  FRAMEBUFFER_START = 16'hE000,
  parameter logic [AW-1:0]  IO_START          = 16'hF000,
  parameter int             KBD_DEPTH         = 16,
  parameter string          INIT_FILE         = "../data/program.hex"
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [AW-1:0] raddr0,
  output logic [DW-1:0] rdata0,
  input  logic          ren,
  input  logic [AW-1:0] raddr1,
  output logic [DW-1:0] rdata1,
  input  logic          wen,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic          kbd_valid,
  input  logic [7:0]    kbd_code,
  output logic          kbd_irq
);

  localparam int RAM_WORDS = int'(TILEMAP_START);
  localparam int TM_WORDS  = int'(FRAMEBUFFER_START) - int'(TILEMAP_START);
  localparam int FB_WORDS  = int'(IO_START) - int'(FRAMEBUFFER_START);
  localparam int RAM_IW    = (RAM_WORDS > 1) ? $clog2(RAM_WORDS) : 1;
  localparam int TM_IW     = (TM_WORDS > 1) ? $clog2(TM_WORDS) : 1;
  localparam int FB_IW     = (FB_WORDS > 1) ? $clog2(FB_WORDS) : 1;
  localparam int KP_W      = $clog2(KBD_DEPTH);
  localparam int KC_W      = KP_W + 1;

  typedef enum logic [1:0] {
    REG_RAM = 2'd0,
    REG_TM  = 2'd1,
    REG_FB  = 2'd2,
    REG_IO  = 2'd3
  } region_e;

  // Same decode for every port: first matching upper bound wins.
  function automatic region_e region_of(input logic [AW-1:0] a);
    if (a < TILEMAP_START)          return REG_RAM;
    else if (a < FRAMEBUFFER_START) return REG_TM;
    else if (a < IO_START)          return REG_FB;
    else                            return REG_IO;
  endfunction

  logic [DW-1:0] ram_mem [RAM_WORDS];
  logic [DW-1:0] tm_mem  [TM_WORDS];
  logic [DW-1:0] fb_mem  [FB_WORDS];
  logic [7:0]    kbd_mem [KBD_DEPTH];

  logic [KP_W-1:0] kbd_rd_ptr_r;
  logic [KP_W-1:0] kbd_wr_ptr_r;
  logic [KC_W-1:0] kbd_cnt_r;
  logic            kbd_ovf_r;
  logic [31:0]     timer_r;
  logic [15:0]     snap_r;
  logic [DW-1:0]   rdata1_r;

  region_e         r0_reg_s, r1_reg_s, w_reg_s;
  logic [AW-1:0]   r1_io_off_s, w_io_off_s;
  logic [DW-1:0]   rd0_s, rd1_s;
  logic [15:0]     io16_s;
  logic [31:0]     cnt_ext_s;
  logic [4:0]      cnt5_s;
  logic            rd_io_s, pop_s, push_s, drop_s, full_s, ovf_clr_s, snap_s;

  // Simulation start-up image: arrays cleared.
  initial begin
    for (int i = 0; i < RAM_WORDS; i++) ram_mem[i] = '0;
    for (int i = 0; i < TM_WORDS; i++)  tm_mem[i]  = '0;
    for (int i = 0; i < FB_WORDS; i++)  fb_mem[i]  = '0;
  end

  assign r0_reg_s    = region_of(raddr0);
  assign r1_reg_s    = region_of(raddr1);
  assign w_reg_s     = region_of(waddr);
  assign r1_io_off_s = raddr1 - IO_START;
  assign w_io_off_s  = waddr - IO_START;

  assign full_s    = (kbd_cnt_r == KC_W'(KBD_DEPTH));
  assign rd_io_s   = ren && (r1_reg_s == REG_IO);
  assign pop_s     = rd_io_s && (r1_io_off_s == AW'(0)) && (kbd_cnt_r != KC_W'(0));
  assign push_s    = kbd_valid && (!full_s || pop_s);
  assign drop_s    = kbd_valid && full_s && !pop_s;
  assign snap_s    = rd_io_s && (r1_io_off_s == AW'(2));
  assign ovf_clr_s = wen && (w_reg_s == REG_IO) && (w_io_off_s == AW'(1));
  assign cnt_ext_s = 32'(kbd_cnt_r);
  assign cnt5_s    = (cnt_ext_s > 32'd31) ? 5'd31 : cnt_ext_s[4:0];
  assign kbd_irq   = (kbd_cnt_r != KC_W'(0));
  assign rdata0    = rd0_s;
  assign rdata1    = rdata1_r;

  // Fetch port: combinational array read, I/O page reads as zero.
  always_comb begin
    rd0_s = '0;
    case (r0_reg_s)
      REG_RAM: rd0_s = ram_mem[RAM_IW'(raddr0)];
      REG_TM:  rd0_s = tm_mem[TM_IW'(raddr0 - TILEMAP_START)];
      REG_FB:  rd0_s = fb_mem[FB_IW'(raddr0 - FRAMEBUFFER_START)];
      default: rd0_s = '0;
    endcase
  end

  // I/O register read value for the data port (side effects live in the flops).
  always_comb begin
    io16_s = 16'h0000;
    case (r1_io_off_s)
      AW'(0): begin
        if (kbd_cnt_r != KC_W'(0)) begin
          io16_s = {1'b1, 7'b0000000, kbd_mem[kbd_rd_ptr_r]};
        end else begin
          io16_s = 16'h0000;
        end
      end
      AW'(1):  io16_s = {kbd_ovf_r, 10'b0000000000, cnt5_s};
      AW'(2):  io16_s = timer_r[15:0];
      AW'(3):  io16_s = snap_r;
      default: io16_s = 16'h0000;
    endcase
  end

  // Data port read mux; arrays are sampled before this edge's write lands.
  always_comb begin
    rd1_s = '0;
    case (r1_reg_s)
      REG_RAM: rd1_s = ram_mem[RAM_IW'(raddr1)];
      REG_TM:  rd1_s = tm_mem[TM_IW'(raddr1 - TILEMAP_START)];
      REG_FB:  rd1_s = fb_mem[FB_IW'(raddr1 - FRAMEBUFFER_START)];
      REG_IO:  rd1_s[15:0] = io16_s;
      default: rd1_s = '0;
    endcase
  end

  // Array write port; reset suppresses a coincident write.
  always_ff @(posedge clk) begin
    if (rst_n && wen) begin
      case (w_reg_s)
        REG_RAM: ram_mem[RAM_IW'(waddr)] <= wdata;
        REG_TM:  tm_mem[TM_IW'(waddr - TILEMAP_START)] <= wdata;
        REG_FB:  fb_mem[FB_IW'(waddr - FRAMEBUFFER_START)] <= wdata;
        default: ;
      endcase
    end
  end

  // Keyboard FIFO storage; a push during reset is discarded.
  always_ff @(posedge clk) begin
    if (rst_n && push_s) begin
      kbd_mem[kbd_wr_ptr_r] <= kbd_code;
    end
  end

  // FIFO pointers, count and sticky overflow flag.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      kbd_rd_ptr_r <= '0;
      kbd_wr_ptr_r <= '0;
      kbd_cnt_r    <= '0;
      kbd_ovf_r    <= 1'b0;
    end else begin
      if (push_s) kbd_wr_ptr_r <= kbd_wr_ptr_r + KP_W'(1);
      if (pop_s)  kbd_rd_ptr_r <= kbd_rd_ptr_r + KP_W'(1);
      case ({push_s, pop_s})
        2'b10:   kbd_cnt_r <= kbd_cnt_r + KC_W'(1);
        2'b01:   kbd_cnt_r <= kbd_cnt_r - KC_W'(1);
        default: kbd_cnt_r <= kbd_cnt_r;
      endcase
      // A dropped code in the same cycle as a clear leaves the flag set.
      if (drop_s)         kbd_ovf_r <= 1'b1;
      else if (ovf_clr_s) kbd_ovf_r <= 1'b0;
    end
  end

  // Free-running timer, high-half snapshot and registered data-port output.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      timer_r  <= 32'd0;
      snap_r   <= 16'h0000;
      rdata1_r <= '0;
    end else begin
      timer_r <= timer_r + 32'd1;
      if (snap_s) snap_r   <= timer_r[31:16];
      if (ren)    rdata1_r <= rd1_s;
    end
  end

endmodule
